// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mips_pkg
//  Brief    : Shared widths, ALU opcode encodings and the packed control
//             bundle carried through the ID/EX, EX/MEM and MEM/WB stages.
//  Revision : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam int DATA_W  = 32;
    localparam int REG_AW  = 5;
    localparam int ALUOP_W = 4;

    // ALU operation encodings understood by the EX stage
    localparam logic [ALUOP_W-1:0] c_alu_add  = 4'h0;
    localparam logic [ALUOP_W-1:0] c_alu_sub  = 4'h1;
    localparam logic [ALUOP_W-1:0] c_alu_and  = 4'h2;
    localparam logic [ALUOP_W-1:0] c_alu_or   = 4'h3;
    localparam logic [ALUOP_W-1:0] c_alu_xor  = 4'h4;
    localparam logic [ALUOP_W-1:0] c_alu_nor  = 4'h5;
    localparam logic [ALUOP_W-1:0] c_alu_slt  = 4'h6;
    localparam logic [ALUOP_W-1:0] c_alu_sltu = 4'h7;
    localparam logic [ALUOP_W-1:0] c_alu_sll  = 4'h8;
    localparam logic [ALUOP_W-1:0] c_alu_srl  = 4'h9;
    localparam logic [ALUOP_W-1:0] c_alu_sra  = 4'hA;
    localparam logic [ALUOP_W-1:0] c_alu_lui  = 4'hB;

    // Control bits that travel with an instruction down the pipeline
    typedef struct packed {
        logic               reg_wr;
        logic               mem_rd;
        logic               mem_wr;
        logic               mem_to_reg;
        logic               alu_src;
        logic [ALUOP_W-1:0] alu_op;
    } ctrl_t;

    // A slot without a real instruction must carry no side effects
    function automatic ctrl_t ctrl_qualify(input ctrl_t c, input logic valid);
        ctrl_t q;
        q = valid ? c : '0;
        return q;
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_use_detect.sv
`default_nettype none
// ============================================================================
//  Module   : load_use_detect
//  Brief    : Flags an ID instruction that reads the destination of a load
//             currently sitting in EX (data not available until after MEM).
//  Revision : 1.0 - initial release
// ============================================================================
module load_use_detect #(
    parameter int REG_AW = 5
) (
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              ex_valid,
    input  logic              ex_mem_rd,
    input  logic [REG_AW-1:0] ex_wreg,
    output logic              hazard
);

    logic w_ex_is_load;
    logic w_rs_match;
    logic w_rt_match;

    // Register 0 is never written, so a load targeting it cannot create a dependence
    always_comb begin
        w_ex_is_load = id_valid && ex_valid && ex_mem_rd && (ex_wreg != '0);
        w_rs_match   = id_uses_rs && (id_rs == ex_wreg);
        w_rt_match   = id_uses_rt && (id_rt == ex_wreg);
        hazard       = w_ex_is_load && (w_rs_match || w_rt_match);
    end

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module   : id_ex_stage
//  Brief    : ID/EX pipeline register with load-use stall, branch flush,
//             downstream hold and a saturating bubble counter.
//  Revision : 1.0 - initial release
// ============================================================================
module id_ex_stage #(
    parameter int DATA_W  = mips_pkg::DATA_W,
    parameter int REG_AW  = mips_pkg::REG_AW,
    parameter int ALUOP_W = mips_pkg::ALUOP_W,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    input  logic [REG_AW-1:0]  id_rs,
    input  logic [REG_AW-1:0]  id_rt,
    input  logic [REG_AW-1:0]  id_rd,
    input  logic               id_uses_rs,
    input  logic               id_uses_rt,
    input  logic [DATA_W-1:0]  id_rd1,
    input  logic [DATA_W-1:0]  id_rd2,
    input  logic [DATA_W-1:0]  id_imm,
    input  logic               id_reg_wr,
    input  logic               id_mem_rd,
    input  logic               id_mem_wr,
    input  logic               id_mem_to_reg,
    input  logic               id_alu_src,
    input  logic               id_reg_dst,
    input  logic [ALUOP_W-1:0] id_alu_op,
    input  logic               flush,
    input  logic               ex_stall,
    output logic               stall_id,
    output logic               ex_valid,
    output logic [REG_AW-1:0]  ex_rs,
    output logic [REG_AW-1:0]  ex_rt,
    output logic [REG_AW-1:0]  ex_wreg,
    output logic [DATA_W-1:0]  ex_rd1,
    output logic [DATA_W-1:0]  ex_rd2,
    output logic [DATA_W-1:0]  ex_imm,
    output logic               ex_reg_wr,
    output logic               ex_mem_rd,
    output logic               ex_mem_wr,
    output logic               ex_mem_to_reg,
    output logic               ex_alu_src,
    output logic [ALUOP_W-1:0] ex_alu_op,
    output logic [CNT_W-1:0]   bubble_cnt
);

    import mips_pkg::*;

    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    logic               w_hazard;
    logic [REG_AW-1:0]  w_dest;
    logic               w_wr_en;
    logic [REG_AW-1:0]  w_wreg;
    ctrl_t              w_ctrl_raw;
    ctrl_t              w_ctrl;
    logic               w_bump;

    logic               r_valid;
    logic [REG_AW-1:0]  r_rs;
    logic [REG_AW-1:0]  r_rt;
    logic [REG_AW-1:0]  r_wreg;
    logic [DATA_W-1:0]  r_rd1;
    logic [DATA_W-1:0]  r_rd2;
    logic [DATA_W-1:0]  r_imm;
    ctrl_t              r_ctrl;
    logic [CNT_W-1:0]   r_bubble_cnt;

    load_use_detect #(
        .REG_AW (REG_AW)
    ) u_load_use_detect (
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rs (id_uses_rs),
        .id_uses_rt (id_uses_rt),
        .ex_valid   (r_valid),
        .ex_mem_rd  (r_ctrl.mem_rd),
        .ex_wreg    (r_wreg),
        .hazard     (w_hazard)
    );

    // Resolve destination and qualify control; register 0 is never a write target
    always_comb begin
        w_dest                = id_reg_dst ? id_rd : id_rt;
        w_wr_en               = id_reg_wr && (w_dest != '0);
        w_wreg                = w_wr_en ? w_dest : '0;
        w_ctrl_raw.reg_wr     = w_wr_en;
        w_ctrl_raw.mem_rd     = id_mem_rd;
        w_ctrl_raw.mem_wr     = id_mem_wr;
        w_ctrl_raw.mem_to_reg = id_mem_to_reg;
        w_ctrl_raw.alu_src    = id_alu_src;
        w_ctrl_raw.alu_op     = id_alu_op;
        w_ctrl                = ctrl_qualify(w_ctrl_raw, id_valid);
    end

    // A flush wins over a hazard: the dependent instruction is dead anyway
    assign stall_id = rst && (ex_stall || (w_hazard && !flush));
    assign w_bump   = !ex_stall && !flush && w_hazard;

    // EX slot: hold under downstream stall, bubble on flush/hazard, else load
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_rs    <= '0;
            r_rt    <= '0;
            r_wreg  <= '0;
            r_rd1   <= '0;
            r_rd2   <= '0;
            r_imm   <= '0;
            r_ctrl  <= '0;
        end else if (ex_stall) begin
            r_valid <= r_valid;
        end else if (flush || w_hazard) begin
            r_valid <= 1'b0;
            r_rs    <= '0;
            r_rt    <= '0;
            r_wreg  <= '0;
            r_rd1   <= '0;
            r_rd2   <= '0;
            r_imm   <= '0;
            r_ctrl  <= '0;
        end else begin
            r_valid <= id_valid;
            r_rs    <= id_rs;
            r_rt    <= id_rt;
            r_wreg  <= w_wreg;
            r_rd1   <= id_rd1;
            r_rd2   <= id_rd2;
            r_imm   <= id_imm;
            r_ctrl  <= w_ctrl;
        end
    end

    // Count load-use bubbles only, saturating so the value never wraps
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bubble_cnt <= '0;
        end else if (w_bump && (r_bubble_cnt != c_cnt_max)) begin
            r_bubble_cnt <= r_bubble_cnt + 1'b1;
        end
    end

    assign ex_valid      = r_valid;
    assign ex_rs         = r_rs;
    assign ex_rt         = r_rt;
    assign ex_wreg       = r_wreg;
    assign ex_rd1        = r_rd1;
    assign ex_rd2        = r_rd2;
    assign ex_imm        = r_imm;
    assign ex_reg_wr     = r_ctrl.reg_wr;
    assign ex_mem_rd     = r_ctrl.mem_rd;
    assign ex_mem_wr     = r_ctrl.mem_wr;
    assign ex_mem_to_reg = r_ctrl.mem_to_reg;
    assign ex_alu_src    = r_ctrl.alu_src;
    assign ex_alu_op     = r_ctrl.alu_op;
    assign bubble_cnt    = r_bubble_cnt;

endmodule
`default_nettype wire
